// File: rtl/macroblock_transfer_buffer.sv
// Store-and-forward macroblock buffer: a block is streamed to the
// destination only once all of its pixels have been committed.
module macroblock_transfer_buffer #(
    parameter int PIXEL_WIDTH  = 24,
    parameter int TYPE_WIDTH   = 2,
    parameter int BLOCK_PIXELS = 64,
    parameter int DEPTH_BLOCKS = 2
) (
    input  logic                          ul1Clock,
    input  logic                          ul1ResetN,
    input  logic                          ul1SrcEnTransfer,
    output logic                          ul1SrcReady,
    input  logic [TYPE_WIDTH-1:0]         eSrcType,
    input  logic [PIXEL_WIDTH-1:0]        ulSrcData,
    input  logic                          ul1Flush,
    output logic                          ul1DstEnTransfer,
    input  logic                          ul1DstReady,
    output logic [TYPE_WIDTH-1:0]         eDstType,
    output logic [PIXEL_WIDTH-1:0]        ulDstData,
    output logic                          ul1DstFirst,
    output logic                          ul1DstLast,
    output logic [$clog2(DEPTH_BLOCKS):0] ulBlockCount,
    output logic                          ul1TypeError
);

    localparam int CAP = BLOCK_PIXELS * DEPTH_BLOCKS;
    localparam int AW  = $clog2(CAP);
    localparam int PW  = $clog2(BLOCK_PIXELS);
    localparam int CW  = $clog2(DEPTH_BLOCKS) + 1;
    localparam int MW  = TYPE_WIDTH + PIXEL_WIDTH;

    localparam logic [AW:0]   CAP_V    = (AW+1)'(CAP);
    localparam logic [PW-1:0] LAST_IDX = PW'(BLOCK_PIXELS - 1);
    localparam logic [CW-1:0] ONE_BLK  = CW'(1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Each word carries its block's latched type alongside the pixel
    logic [MW-1:0]          r_mem [CAP];
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_cmt_ptr;
    logic [AW:0]            r_rd_ptr;
    logic [TYPE_WIDTH-1:0]  r_lat_type;
    logic                   r_run;
    logic                   r_type_err;
    logic [CW-1:0]          r_cnt;
    state_t                 r_state;
    logic                   r_dst_vld;
    logic                   r_dst_first;
    logic                   r_dst_last;
    logic [TYPE_WIDTH-1:0]  r_dst_type;
    logic [PIXEL_WIDTH-1:0] r_dst_data;

    logic [AW:0]            w_fill;
    logic                   w_full;
    logic                   w_src_rdy;
    logic [PW-1:0]          w_in_idx;
    logic                   w_first_in;
    logic                   w_acc;
    logic                   w_commit;
    logic [TYPE_WIDTH-1:0]  w_wtype;
    logic                   w_dst_hs;
    logic                   w_release;
    logic                   w_more;
    logic [AW:0]            w_rd_nxt;
    logic [MW-1:0]          w_rd_word;
    logic [MW-1:0]          w_nx_word;

    assign w_fill     = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_fill == CAP_V);
    assign w_src_rdy  = r_run && !w_full && !ul1Flush;
    assign w_in_idx   = r_wr_ptr[PW-1:0];
    assign w_first_in = (w_in_idx == '0);
    assign w_acc      = ul1SrcEnTransfer && w_src_rdy;
    assign w_commit   = w_acc && (w_in_idx == LAST_IDX);
    assign w_wtype    = w_first_in ? eSrcType : r_lat_type;
    assign w_dst_hs   = r_dst_vld && ul1DstReady;
    assign w_release  = w_dst_hs && r_dst_last;
    // Another committed block exists, or one commits on this very edge
    assign w_more     = (r_cnt > ONE_BLK) || w_commit;
    assign w_rd_nxt   = r_rd_ptr + 1'b1;
    assign w_rd_word  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_nx_word  = r_mem[w_rd_nxt[AW-1:0]];

    always_ff @(posedge ul1Clock) begin
        if (w_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_wtype, ulSrcData};
        end
    end

    always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
        if (!ul1ResetN) begin
            r_run      <= 1'b0;
            r_wr_ptr   <= '0;
            r_cmt_ptr  <= '0;
            r_lat_type <= '0;
            r_type_err <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (ul1Flush) begin
                r_wr_ptr <= r_cmt_ptr;
            end else if (w_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_first_in) begin
                    r_lat_type <= eSrcType;
                end else if (eSrcType != r_lat_type) begin
                    r_type_err <= 1'b1;
                end
                if (w_commit) begin
                    r_cmt_ptr <= r_wr_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
        if (!ul1ResetN) begin
            r_cnt <= '0;
        end else if (w_commit && !w_release) begin
            r_cnt <= r_cnt + ONE_BLK;
        end else if (!w_commit && w_release) begin
            r_cnt <= r_cnt - ONE_BLK;
        end
    end

    always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
        if (!ul1ResetN) begin
            r_state     <= IDLE;
            r_rd_ptr    <= '0;
            r_dst_vld   <= 1'b0;
            r_dst_first <= 1'b0;
            r_dst_last  <= 1'b0;
            r_dst_type  <= '0;
            r_dst_data  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_cnt != '0) begin
                        r_state     <= STREAM;
                        r_dst_vld   <= 1'b1;
                        r_dst_first <= 1'b1;
                        r_dst_last  <= 1'b0;
                        {r_dst_type, r_dst_data} <= w_rd_word;
                    end
                end
                STREAM: begin
                    if (w_dst_hs) begin
                        r_rd_ptr <= w_rd_nxt;
                        if (r_dst_last && !w_more) begin
                            r_state     <= IDLE;
                            r_dst_vld   <= 1'b0;
                            r_dst_first <= 1'b0;
                            r_dst_last  <= 1'b0;
                        end else begin
                            {r_dst_type, r_dst_data} <= w_nx_word;
                            r_dst_first <= r_dst_last;
                            r_dst_last  <= (w_rd_nxt[PW-1:0] == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ul1SrcReady      = w_src_rdy;
    assign ul1DstEnTransfer = r_dst_vld;
    assign eDstType         = r_dst_type;
    assign ulDstData        = r_dst_data;
    assign ul1DstFirst      = r_dst_first;
    assign ul1DstLast       = r_dst_last;
    assign ulBlockCount     = r_cnt;
    assign ul1TypeError     = r_type_err;

endmodule

// File: tb/tb_macroblock_transfer_buffer.sv
// Directed and randomized bench for macroblock_transfer_buffer
// with 4-pixel blocks and two-block storage.
module tb_macroblock_transfer_buffer;

    localparam int BP  = 4;
    localparam int DB  = 2;
    localparam int NP  = 4000;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        src_en   = 1'b0;
    logic        flush    = 1'b0;
    logic        dst_rdy  = 1'b0;
    logic [1:0]  src_type = '0;
    logic [23:0] src_data = '0;
    logic        src_rdy;
    logic        dst_vld;
    logic [1:0]  dst_type;
    logic [23:0] dst_data;
    logic        dst_first;
    logic        dst_last;
    logic [1:0]  blk_cnt;
    logic        type_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_acc = 0;
    bit s2_done = 1'b0;

    logic [27:0] q_out [$];
    int          q_cyc [$];

    macroblock_transfer_buffer #(
        .PIXEL_WIDTH (24),
        .TYPE_WIDTH  (2),
        .BLOCK_PIXELS(BP),
        .DEPTH_BLOCKS(DB)
    ) dut (
        .ul1Clock        (clk),
        .ul1ResetN       (rst_n),
        .ul1SrcEnTransfer(src_en),
        .ul1SrcReady     (src_rdy),
        .eSrcType        (src_type),
        .ulSrcData       (src_data),
        .ul1Flush        (flush),
        .ul1DstEnTransfer(dst_vld),
        .ul1DstReady     (dst_rdy),
        .eDstType        (dst_type),
        .ulDstData       (dst_data),
        .ul1DstFirst     (dst_first),
        .ul1DstLast      (dst_last),
        .ulBlockCount    (blk_cnt),
        .ul1TypeError    (type_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are decided by values stable since the prior edge
    always @(negedge clk) begin
        if (rst_n && dst_vld && dst_rdy) begin
            q_out.push_back({dst_first, dst_last, dst_type, dst_data});
            q_cyc.push_back(cyc);
        end
        if (rst_n && src_en && src_rdy) n_acc <= n_acc + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ew(input bit f, input bit l,
                                       input logic [1:0] t,
                                       input logic [23:0] d);
        return {4'b0, f, l, t, d};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] d, input logic [1:0] t);
        bit ok;
        ok = 1'b0;
        src_en = 1'b1;
        src_data = d;
        src_type = t;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (src_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        src_en = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 200 && q_out.size() < n; k++) tick();
        chk("out_count", 32'(q_out.size()), 32'(n));
    endtask

    task automatic check_blk(input string tag, input int base,
                             input logic [23:0] d0,
                             input logic [1:0] t);
        for (int i = 0; i < BP; i++) begin
            chk(tag, {4'b0, q_out[base+i]},
                ew(i == 0, i == BP-1, t, d0 + 24'(i)));
        end
    endtask

    initial begin
        int e0;
        // Reset values
        tick(2);
        chk("rst_srdy", 32'(src_rdy), 0);
        chk("rst_vld", 32'(dst_vld), 0);
        chk("rst_first", 32'(dst_first), 0);
        chk("rst_last", 32'(dst_last), 0);
        chk("rst_cnt", 32'(blk_cnt), 0);
        chk("rst_data", 32'(dst_data), 0);
        chk("rst_type", 32'(dst_type), 0);
        chk("rst_err", 32'(type_err), 0);
        rst_n = 1'b1;
        chk("rel_srdy0", 32'(src_rdy), 0);
        tick();
        chk("rel_srdy1", 32'(src_rdy), 1);

        // Single block, 2-cycle latency
        dst_rdy = 1'b1;
        for (int i = 0; i < BP; i++) send(24'(i + 1), 2'd2);
        chk("lat_vld0", 32'(dst_vld), 0);
        chk("lat_cnt1", 32'(blk_cnt), 1);
        tick();
        chk("lat_vld1", 32'(dst_vld), 1);
        chk("lat_word", {4'b0, dst_first, dst_last, dst_type, dst_data},
            ew(1, 0, 2'd2, 24'h000001));
        wait_out(4);
        check_blk("t1_px", 0, 24'h000001, 2'd2);
        tick(2);
        chk("t1_cnt0", 32'(blk_cnt), 0);

        // Back-pressure fills storage, then drains back to back
        q_out.delete();
        q_cyc.delete();
        dst_rdy = 1'b0;
        e0 = n_acc;
        fork
            begin
                for (int i = 0; i < 12; i++) send(24'(100 + i), 2'd1);
                s2_done = 1'b1;
            end
        join_none
        tick(20);
        chk("full_acc", 32'(n_acc - e0), 8);
        chk("full_srdy", 32'(src_rdy), 0);
        chk("full_cnt", 32'(blk_cnt), 2);
        chk("stall_vld", 32'(dst_vld), 1);
        chk("stall_data", 32'(dst_data), 100);
        chk("stall_first", 32'(dst_first), 1);
        dst_rdy = 1'b1;
        wait_out(12);
        for (int k = 0; k < 50 && !s2_done; k++) tick();
        chk("t2_src_done", 32'(s2_done), 1);
        check_blk("t2_b0", 0, 24'd100, 2'd1);
        check_blk("t2_b1", 4, 24'd104, 2'd1);
        check_blk("t2_b2", 8, 24'd108, 2'd1);
        chk("t2_b2b", 32'(q_cyc[7] - q_cyc[0]), 7);

        // Flush discards a partial block
        tick(3);
        q_out.delete();
        send(24'h71, 2'd2);
        send(24'h72, 2'd2);
        send(24'h73, 2'd2);
        tick(3);
        chk("part_noout", 32'(q_out.size()), 0);
        chk("part_vld", 32'(dst_vld), 0);
        src_en = 1'b1;
        src_data = 24'hEE;
        flush = 1'b1;
        #1;
        chk("flush_srdy", 32'(src_rdy), 0);
        tick();
        flush = 1'b0;
        src_en = 1'b0;
        for (int i = 0; i < BP; i++) send(24'hA + 24'(i), 2'd0);
        wait_out(4);
        tick(4);
        chk("t3_count", 32'(q_out.size()), 4);
        check_blk("t3_px", 0, 24'h00000A, 2'd0);

        // Type change inside a block
        q_out.delete();
        chk("t4_err0", 32'(type_err), 0);
        send(24'h21, 2'd1);
        send(24'h22, 2'd1);
        send(24'h23, 2'd3);
        send(24'h24, 2'd1);
        chk("t4_err1", 32'(type_err), 1);
        wait_out(4);
        check_blk("t4_px", 0, 24'h21, 2'd1);
        tick(3);
        chk("t4_sticky", 32'(type_err), 1);

        // Reset mid-block and mid-stream
        dst_rdy = 1'b0;
        for (int i = 0; i < 6; i++) send(24'h41 + 24'(i), 2'd2);
        tick(2);
        q_out.delete();
        dst_rdy = 1'b1;
        tick(2);
        dst_rdy = 1'b0;
        chk("t5_two", 32'(q_out.size()), 2);
        chk("t5_px1", {4'b0, q_out[1]}, ew(0, 0, 2'd2, 24'h42));
        rst_n = 1'b0;
        #1;
        chk("t5_vld", 32'(dst_vld), 0);
        chk("t5_cnt", 32'(blk_cnt), 0);
        chk("t5_srdy", 32'(src_rdy), 0);
        chk("t5_data", 32'(dst_data), 0);
        chk("t5_flags", {30'b0, dst_first, dst_last}, 0);
        chk("t5_err", 32'(type_err), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_srdy1", 32'(src_rdy), 1);
        q_out.delete();
        dst_rdy = 1'b1;
        for (int i = 0; i < BP; i++) send(24'h51 + 24'(i), 2'd3);
        wait_out(4);
        tick(4);
        chk("t5_fresh_n", 32'(q_out.size()), 4);
        check_blk("t5_fresh", 0, 24'h51, 2'd3);

        // Random valid/ready on both sides
        q_out.delete();
        fork
            begin
                int sent;
                sent = 0;
                for (int c = 0; c < 60000 && sent < NP; c++) begin
                    src_en = 1'($urandom_range(0, 1));
                    src_data = 24'(sent * 37 + 5);
                    src_type = 2'((sent / BP) % 4);
                    @(negedge clk);
                    if (src_en && src_rdy) sent++;
                    @(posedge clk);
                    #1;
                end
                src_en = 1'b0;
            end
            begin
                for (int c = 0; c < 60000 && q_out.size() < NP; c++) begin
                    dst_rdy = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                dst_rdy = 1'b1;
            end
        join
        tick(4);
        chk("rnd_count", 32'(q_out.size()), NP);
        e0 = n_err;
        for (int i = 0; i < q_out.size() && n_err == e0; i++) begin
            chk("rnd_px", {4'b0, q_out[i]},
                ew(i % BP == 0, i % BP == BP-1,
                   2'((i / BP) % 4), 24'(i * 37 + 5)));
        end
        chk("rnd_err", 32'(type_err), 0);
        chk("rnd_cnt0", 32'(blk_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
